// File: rtl/wb_defs.sv
// Shared Wishbone burst definitions: BTE/CTI encodings, slave FSM states and a byte-lane merge helper.
package wb_defs;

  typedef enum logic [1:0] {
    LINEAR = 2'b00,
    BEAT4  = 2'b01,
    BEAT8  = 2'b10,
    BEAT16 = 2'b11
  } bte_t;

  typedef enum logic [2:0] {
    CLASSIC = 3'b000,
    INC     = 3'b010,
    EOB     = 3'b111
  } cti_t;

  typedef enum logic [1:0] {
    IDLE,
    LAT,
    CLS_ACK,
    BURST
  } state_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_burst_adr_gen.sv
// Next word address of a Wishbone incrementing burst for linear and wrap-4/8/16 burst types.
module wb_burst_adr_gen
  import wb_defs::*;
#(
  parameter int AW = 10
) (
  input  logic [AW-1:0] cur_adr,
  input  logic [1:0]    bte,
  output logic [AW-1:0] next_adr
);

  logic [AW-1:0] inc;
  logic [AW-1:0] wrap_mask;

  // Bits inside the mask take the incremented value; bits above it stay put.
  always_comb begin
    inc = cur_adr + AW'(1);
    case (bte)
      BEAT4:   wrap_mask = AW'(3);
      BEAT8:   wrap_mask = AW'(7);
      BEAT16:  wrap_mask = AW'(15);
      default: wrap_mask = '1;
    endcase
    next_adr = (cur_adr & ~wrap_mask) | (inc & wrap_mask);
  end

endmodule

// File: rtl/wbs_burst_ram.sv
// Wishbone B3 registered-feedback slave over a 2^AW x 32 synchronous RAM with classic and burst cycles.
module wbs_burst_ram
  import wb_defs::*;
#(
  parameter int    AW        = 10,
  parameter int    WAIT      = 0,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] adr_i,
  input  logic [1:0]  bte_i,
  input  logic [2:0]  cti_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  output logic [31:0] dat_o,
  output logic        ack_o
);

  localparam int DEPTH = 1 << AW;

  logic [31:0]   mem [DEPTH];
  state_t        state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic [AW-1:0] cur_adr, adr_nx, next_adr, rd_adr, req_adr;
  logic          ack_nx, rd_load, wr_en;
  logic          unused_adr;

  assign req_adr    = adr_i[AW+1:2];
  assign unused_adr = ^{adr_i[31:AW+2], adr_i[1:0]};
  assign wr_en      = ack_o & stb_i & we_i;

  wb_burst_adr_gen #(.AW(AW)) u_adr_gen (
    .cur_adr  (cur_adr),
    .bte      (bte_i),
    .next_adr (next_adr)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    adr_nx   = cur_adr;
    ack_nx   = 1'b0;
    rd_load  = 1'b0;
    rd_adr   = cur_adr;
    case (state)
      IDLE: begin
        if (cyc_i && stb_i) begin
          adr_nx = req_adr;
          rd_adr = req_adr;
          cnt_nx = 4'(WAIT);
          if (WAIT > 0) begin
            state_nx = LAT;
          end else begin
            state_nx = (cti_i == INC) ? BURST : CLS_ACK;
            ack_nx   = 1'b1;
            rd_load  = 1'b1;
          end
        end
      end
      LAT: begin
        if (!cyc_i) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt <= 4'd1) begin
          cnt_nx   = '0;
          state_nx = (cti_i == INC) ? BURST : CLS_ACK;
          ack_nx   = 1'b1;
          rd_load  = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      CLS_ACK: state_nx = IDLE;
      BURST: begin
        if (!cyc_i) begin
          state_nx = IDLE;
        end else if (ack_o && stb_i) begin
          if (cti_i != INC) begin
            state_nx = IDLE;
          end else begin
            adr_nx  = next_adr;
            rd_adr  = next_adr;
            ack_nx  = 1'b1;
            rd_load = 1'b1;
          end
        end else if (stb_i) begin
          // Resume after a strobe gap: re-read the held address, no extra wait.
          ack_nx  = 1'b1;
          rd_load = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      cur_adr <= '0;
      ack_o   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      cur_adr <= adr_nx;
      ack_o   <= ack_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (sel_i[b]) mem[cur_adr][8*b +: 8] <= dat_i[8*b +: 8];
      end
    end
  end

  // Write-first: a prefetch hitting the word being written sees the new bytes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dat_o <= '0;
    end else if (rd_load) begin
      if (wr_en && rd_adr == cur_adr) dat_o <= byte_merge(mem[cur_adr], dat_i, sel_i);
      else                            dat_o <= mem[rd_adr];
    end
  end

endmodule

// File: tb/tb_wbs_burst_ram.sv
// Scoreboard bench for wbs_burst_ram: one instance with WAIT=0 and one with WAIT=3 on a shared bus.
module tb_wbs_burst_ram;

  localparam int W0 = 0;
  localparam int W1 = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] adr, dat_w;
  logic [1:0]  bte;
  logic [2:0]  cti;
  logic [3:0]  sel;
  logic        we, stb, cyc0, cyc1;
  logic [31:0] dat0, dat1;
  logic        ack0, ack1;
  bit          cur_dut;
  logic        s_ack;
  logic [31:0] s_dat;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model [int];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  assign s_ack = cur_dut ? ack1 : ack0;
  assign s_dat = cur_dut ? dat1 : dat0;

  wbs_burst_ram #(.AW(10), .WAIT(W0)) dut0 (
    .clk(clk), .reset(reset), .adr_i(adr), .bte_i(bte), .cti_i(cti), .dat_i(dat_w),
    .sel_i(sel), .we_i(we), .cyc_i(cyc0), .stb_i(stb), .dat_o(dat0), .ack_o(ack0)
  );

  wbs_burst_ram #(.AW(10), .WAIT(W1)) dut1 (
    .clk(clk), .reset(reset), .adr_i(adr), .bte_i(bte), .cti_i(cti), .dat_i(dat_w),
    .sel_i(sel), .we_i(we), .cyc_i(cyc1), .stb_i(stb), .dat_o(dat1), .ack_o(ack1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int mkey(input bit d, input int word);
    return (d ? 4096 : 0) + word;
  endfunction

  function automatic int beat_word(input int start, input logic [1:0] b, input int k);
    int len;
    case (b)
      2'b01:   len = 4;
      2'b10:   len = 8;
      2'b11:   len = 16;
      default: len = 0;
    endcase
    if (len == 0) return (start + k) % 1024;
    return (start - start % len) + (start % len + k) % len;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = s[i/8] ? new_w[i] : old_w[i];
    return r;
  endfunction

  task automatic set_cyc(input logic v);
    cyc0 = v && !cur_dut;
    cyc1 = v && cur_dut;
  endtask

  task automatic classic(input bit d, input bit wr, input logic [31:0] a,
                         input logic [31:0] data, input logic [3:0] s);
    int n = 0;
    int k = mkey(d, int'(a[11:2]));
    cur_dut = d;
    adr = a; dat_w = data; sel = s; we = wr; cti = 3'b000; bte = 2'b00; stb = 1'b1;
    set_cyc(1'b1);
    if (!wr) exp_q.push_back(model[k]);
    do begin
      @(negedge clk);
      n++;
    end while (!s_ack && n < 40);
    chk(wr ? "cls wr latency" : "cls rd latency", n, (d ? W1 : W0) + 1);
    if (s_ack) begin
      if (wr) model[k] = merge(model.exists(k) ? model[k] : 32'h0, data, s);
      else    chk("cls rd data", s_dat, exp_q.pop_front());
    end else if (!wr) begin
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
    set_cyc(1'b0);
    chk("cls ack one cycle", s_ack, 0);
  endtask

  task automatic beat_drive(input bit d, input bit wr, input int w0, input logic [1:0] b,
                            input int k, input int nb, input logic [31:0] dbase);
    int w = beat_word(w0, b, k);
    adr   = 32'(w) << 2;
    dat_w = dbase + 32'(k);
    cti   = (k == nb - 1) ? 3'b111 : 3'b010;
    stb   = 1'b1;
    if (!wr) exp_q.push_back(model[mkey(d, w)]);
  endtask

  task automatic burst(input bit d, input bit wr, input logic [31:0] a, input logic [1:0] b,
                       input int nb, input logic [31:0] dbase, input int stall_at,
                       input int stall_len, input int abort_at);
    int i = 0, n = 0, first = 0, last = 0;
    int w0 = int'(a[11:2]);
    int lat = (d ? W1 : W0) + 1;
    bit pend = 1'b0, done = 1'b0;
    cur_dut = d; bte = b; we = wr; sel = 4'hF;
    beat_drive(d, wr, w0, b, 0, nb, dbase);
    set_cyc(1'b1);
    while (!done) begin
      @(negedge clk);
      n++;
      if (pend) begin
        pend = 1'b0;
        i++;
        if (i == nb) begin
          stb = 1'b0; we = 1'b0;
          set_cyc(1'b0);
          chk("eob ack off", s_ack, 0);
          done = 1'b1;
        end else begin
          if (i == stall_at) begin
            stb = 1'b0;
            repeat (stall_len - 1) begin
              @(negedge clk);
              n++;
              chk("stall no ack", s_ack, 0);
            end
            @(negedge clk);
            n++;
          end
          beat_drive(d, wr, w0, b, i, nb, dbase);
        end
      end
      if (!done) begin
        if (s_ack && stb) begin
          if (first == 0) first = n;
          last = n;
          if (i == abort_at) begin
            reset = 1'b0;
            @(negedge clk);
            chk("abort ack off", s_ack, 0);
            reset = 1'b1; stb = 1'b0; we = 1'b0;
            set_cyc(1'b0);
            @(negedge clk);
            chk("post abort idle", s_ack, 0);
            if (!wr) void'(exp_q.pop_front());
            done = 1'b1;
          end else begin
            pend = 1'b1;
            if (wr) model[mkey(d, beat_word(w0, b, i))] = dat_w;
            else    chk("burst rd data", s_dat, exp_q.pop_front());
          end
        end
        if (n > 200) begin
          chk("burst timeout", n, 0);
          stb = 1'b0;
          set_cyc(1'b0);
          done = 1'b1;
        end
      end
    end
    if (stall_at < 0 && abort_at < 0 && first != 0) begin
      chk("burst first ack", first, lat);
      chk("burst ack span", last, lat + nb - 1);
    end
  endtask

  initial begin
    reset = 1'b0; adr = '0; dat_w = '0; bte = '0; cti = '0; sel = '0;
    we = 1'b0; stb = 1'b0; cyc0 = 1'b0; cyc1 = 1'b0; cur_dut = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset ack0", ack0, 0);
    chk("reset dat0", dat0, 0);
    chk("reset ack1", ack1, 0);
    chk("reset dat1", dat1, 0);
    reset = 1'b1;
    @(negedge clk);

    classic(0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
    classic(0, 0, 32'h10, 32'h0, 4'hF);
    classic(0, 1, 32'h20, 32'h11223344, 4'hF);
    classic(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101);
    classic(0, 0, 32'h20, 32'h0, 4'hF);
    classic(0, 1, 32'h20, 32'h55555555, 4'h0);
    classic(0, 0, 32'h1020, 32'h0, 4'hF);

    for (int k = 0; k < 4; k++) classic(0, 1, 32'h40 + 32'(4 * k), 32'(k + 1), 4'hF);
    burst(0, 0, 32'h48, 2'b01, 4, 32'h0, -1, 0, -1);

    burst(0, 1, 32'h100, 2'b00, 8, 32'hA000_0000, 3, 2, -1);
    burst(0, 0, 32'h100, 2'b00, 8, 32'h0, -1, 0, -1);
    classic(0, 0, 32'h10C, 32'h0, 4'hF);

    burst(0, 1, 32'h300, 2'b00, 8, 32'hB0, -1, 0, -1);
    burst(0, 0, 32'h314, 2'b10, 8, 32'h0, -1, 0, -1);
    burst(0, 1, 32'hFF8, 2'b00, 4, 32'hC0, -1, 0, -1);
    classic(0, 0, 32'h0, 32'h0, 4'hF);

    classic(1, 1, 32'h80, 32'h12345678, 4'hF);
    classic(1, 0, 32'h80, 32'h0, 4'hF);
    burst(1, 1, 32'h90, 2'b00, 4, 32'hD0, -1, 0, -1);
    burst(1, 0, 32'h90, 2'b00, 4, 32'h0, -1, 0, -1);

    cur_dut = 1'b1; adr = 32'h80; we = 1'b0; cti = 3'b000; stb = 1'b1;
    set_cyc(1'b1);
    repeat (2) @(negedge clk);
    set_cyc(1'b0);
    stb = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("lat abort no ack", s_ack, 0);
    end

    burst(0, 1, 32'h200, 2'b00, 16, 32'hE0, -1, 0, 2);
    classic(0, 0, 32'h200, 32'h0, 4'hF);
    classic(0, 0, 32'h204, 32'h0, 4'hF);

    chk("scoreboard empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
